leaf_stream_packetizer: RTL and testbench
=========================================

# leaf_stream_packetizer

Per-output-port packetizer on the user-to-network side of a leaf. It accepts one 32-bit AXI-stream-style output from the user kernel, buffers it in a small FIFO, and wraps each word into a 49-bit BFT packet addressed to a configured destination leaf/port. Packets are released only while the destination input buffer has free space, tracked with a credit counter. The leaf's output arbiter consumes the packets and injects them into `dout_leaf_interface2bft`.

## Interface
Parameters:
- `PACKET_BITS`, 49, packet width
- `PAYLOAD_BITS`, 32, payload width
- `NUM_LEAF_BITS`, 5, destination leaf field width
- `NUM_PORT_BITS`, 4, destination port field width
- `NUM_ADDR_BITS`, 7, destination BRAM write-address field width
- `FIFO_DEPTH`, 16, input buffer depth (power of 2)
- `FREESPACE_UPDATE_SIZE`, 64, credits returned per update pulse

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `din` in 32: user stream data
- `vld` in 1: user stream valid
- `ack` out 1: user stream ready (= FIFO not full)
- `cfg_vld` in 1: one-cycle destination load strobe
- `cfg_leaf` in 5: destination leaf
- `cfg_port` in 4: destination port
- `credit_upd` in 1: one-cycle freespace-update strobe from the receiver
- `pkt_out` out 49: packet `{1'b1, leaf[4:0], port[3:0], addr[6:0], payload[31:0]}`
- `pkt_vld` out 1: packet valid toward the arbiter
- `pkt_ack` in 1: arbiter grant; consumes `pkt_out` this cycle
- `sent_count` out 32: packets sent (only with the macro)

## Operation
- The FSM has three states:
  - UNCFG (reset state): the FIFO accepts data, nothing is emitted. `cfg_vld` moves it to IDLE.
  - IDLE: when the FIFO is non-empty and `credit != 0`, pop a word, build the packet register and go to SEND.
  - SEND: hold `pkt_out`/`pkt_vld` stable until `pkt_ack`. On ack, if the FIFO is non-empty and `credit_next != 0`, load the next packet in the same cycle and stay in SEND. Otherwise go to IDLE.
- `cfg_vld` is honoured in any state. It updates the leaf/port registers and resets `addr` to 0. A packet already in SEND keeps its old header.
- `addr` increments modulo 2^NUM_ADDR_BITS on each packet acked (127 wraps to 0).
- Credit counter:
  - Width `NUM_ADDR_BITS+1`; reset value 2^NUM_ADDR_BITS (128).
  - Decrements on each credit-consuming load (one credit per packet).
  - Adds `FREESPACE_UPDATE_SIZE` on `credit_upd`.
  - On a simultaneous load and update, the net change (+63) is applied in one cycle.
  - Never exceeds 128: an update that would overflow saturates at 128 and fires a simulation assertion.
- FIFO:
  - Write when `vld && ack`. `ack` = !full, registered.
  - Simultaneous push and pop is legal at full (pop frees the slot next cycle; `ack` stays low this cycle) and at empty (the word is not visible until the next cycle).
- Reset mid-operation:
  - Drops the FIFO contents and any packet in SEND.
  - Returns to UNCFG with credit at 128 and `addr` at 0.
  - Clears the destination registers.

## Timing
- Reset values: `ack`=0 during reset and 1 the cycle after; `pkt_vld`=0; `pkt_out`=0; `sent_count`=0.
- Latency: a word written at cycle N (configured, credit available, FIFO empty) gives `pkt_vld`=1 at N+2.
- Throughput: one packet per cycle while `pkt_ack` is held high and credit and data are available.
- `pkt_vld` never drops without `pkt_ack`. `pkt_out` is stable while `pkt_vld && !pkt_ack`.
- Credit reaching 0 blocks the next load. After `credit_upd`, the earliest load is the following cycle.

## Configuration
- `PACKETIZER_STATS_EN` defined: `sent_count` increments by 1 on each `pkt_vld && pkt_ack`, wraps at 2^32, and is cleared by reset.
- Undefined: `sent_count` is tied to 0 and no counter logic is built.

## Test plan
- Basic:
  - Stimulus: reset; cfg leaf=3, port=2; push 0xDEADBEEF; hold `pkt_ack`=1.
  - Response: `pkt_out`=`{1,5'd3,4'd2,7'd0,32'hDEADBEEF}` two cycles after the push; `addr` of the next packet = 1.
- Credit exhaustion:
  - Stimulus: push 130 words with no `credit_upd`.
  - Response: exactly 128 packets sent, 2 remain in the FIFO. One `credit_upd` releases both; final credit = 62.
- Backpressure:
  - Stimulus: hold `pkt_ack`=0 for 20 cycles with a stream pushing.
  - Response: `ack` drops after 16 words + 1 held packet; `pkt_out` stays constant; on release, words emerge in order.
- Wrap and reconfig:
  - Stimulus: send 129 packets with credit topped up.
  - Response: the 129th packet carries `addr`=0. A `cfg_vld` mid-stream gives the next packet the new leaf/port and `addr`=0.
- Simultaneous credit update and packet load, then reset during SEND:
  - Response: credit changes by +63 in one cycle. After the reset, `pkt_vld`=0 next cycle, FSM in UNCFG, credit=128.
- Stats:
  - Stimulus: with `PACKETIZER_STATS_EN` defined, send 10 packets.
  - Response: `sent_count`=10. Without the macro, `sent_count`=0 throughout.

Source files
------------

// File: rtl/leaf_stream_packetizer.sv
// leaf_stream_packetizer
// Buffers a 32-bit user stream in a small FIFO and wraps each word into a
// BFT packet for a configured destination leaf/port. Packets are released
// only while the credit counter says the receiver has free buffer space.
// Optional feature: define PACKETIZER_STATS_EN to build the sent-packet counter.
module leaf_stream_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FIFO_DEPTH            = 16,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PAYLOAD_BITS-1:0]  din,
  input  logic                     vld,
  output logic                     ack,
  input  logic                     cfg_vld,
  input  logic [NUM_LEAF_BITS-1:0] cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_port,
  input  logic                     credit_upd,
  output logic [PACKET_BITS-1:0]   pkt_out,
  output logic                     pkt_vld,
  input  logic                     pkt_ack,
  output logic [31:0]              sent_count
);

  localparam int PTR_BITS    = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS    = PTR_BITS + 1;
  localparam int CREDIT_BITS = NUM_ADDR_BITS + 1;
  localparam int SUM_BITS    = CREDIT_BITS + 1;
  localparam int CREDIT_MAX  = 1 << NUM_ADDR_BITS;

  typedef enum logic [1:0] {UNCFG, IDLE, SEND} state_t;

  state_t                   state_q, state_d;
  logic [PAYLOAD_BITS-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0]      count_q, count_d;
  logic                     ack_q, ack_d;
  logic [CREDIT_BITS-1:0]   credit_q, credit_d;
  logic [NUM_LEAF_BITS-1:0] leaf_q, leaf_d;
  logic [NUM_PORT_BITS-1:0] port_q, port_d;
  logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [PACKET_BITS-1:0]   pkt_q, pkt_d;
  logic                     pkt_vld_q, pkt_vld_d;

  logic                     push;
  logic                     load;
  logic                     credit_ovf;
  logic [NUM_LEAF_BITS-1:0] hdr_leaf;
  logic [NUM_PORT_BITS-1:0] hdr_port;
  logic [NUM_ADDR_BITS-1:0] addr_base;
  logic [SUM_BITS-1:0]      credit_sum;

  assign ack     = ack_q;
  assign pkt_out = pkt_q;
  assign pkt_vld = pkt_vld_q;

  // Next-state logic: FSM, FIFO bookkeeping, packet build, header and credit tracking
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pkt_d      = pkt_q;
    load       = 1'b0;
    push       = vld && ack_q;
    // A same-cycle cfg_vld already applies to a packet loaded in that cycle
    hdr_leaf   = cfg_vld ? cfg_leaf : leaf_q;
    hdr_port   = cfg_vld ? cfg_port : port_q;
    addr_base  = cfg_vld ? '0 : addr_q;

    case (state_q)
      UNCFG: begin
        if (cfg_vld) state_d = IDLE;
      end
      IDLE: begin
        if ((count_q != '0) && (credit_q != '0)) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (pkt_ack) begin
          if ((count_q != '0) && (credit_q != '0)) load = 1'b1;
          else state_d = IDLE;
        end
      end
      default: state_d = UNCFG;
    endcase

    pkt_vld_d = (state_d == SEND);

    if (load) begin
      pkt_d    = {1'b1, hdr_leaf, hdr_port, addr_base, fifo_mem[rd_ptr_q]};
      rd_ptr_d = rd_ptr_q + 1'b1;
      addr_d   = addr_base + 1'b1;
    end else begin
      addr_d   = addr_base;
    end
    leaf_d = hdr_leaf;
    port_d = hdr_port;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    count_d = count_q + CNT_BITS'(push) - CNT_BITS'(load);
    ack_d   = (count_d != CNT_BITS'(FIFO_DEPTH));

    credit_sum = {1'b0, credit_q} - SUM_BITS'(load)
               + (credit_upd ? SUM_BITS'(FREESPACE_UPDATE_SIZE) : SUM_BITS'(0));
    credit_ovf = (credit_sum > SUM_BITS'(CREDIT_MAX));
    credit_d   = credit_ovf ? CREDIT_BITS'(CREDIT_MAX) : credit_sum[CREDIT_BITS-1:0];
  end

  // State registers; reset drops buffered data and any packet in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= UNCFG;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ack_q     <= 1'b0;
      credit_q  <= CREDIT_BITS'(CREDIT_MAX);
      leaf_q    <= '0;
      port_q    <= '0;
      addr_q    <= '0;
      pkt_q     <= '0;
      pkt_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ack_q     <= ack_d;
      credit_q  <= credit_d;
      leaf_q    <= leaf_d;
      port_q    <= port_d;
      addr_q    <= addr_d;
      pkt_q     <= pkt_d;
      pkt_vld_q <= pkt_vld_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (!reset && push) fifo_mem[wr_ptr_q] <= din;
  end

  // The receiver must never return more space than its buffer holds
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!credit_ovf);
    end
  end

`ifdef PACKETIZER_STATS_EN
  logic [31:0] sent_q, sent_d;

  // Count every packet the arbiter accepts, wrapping naturally at 2^32
  always_comb begin
    sent_d = sent_q;
    if (pkt_vld_q && pkt_ack) sent_d = sent_q + 32'd1;
  end

  // Statistics register
  always_ff @(posedge clk) begin
    if (reset) sent_q <= '0;
    else       sent_q <= sent_d;
  end

  assign sent_count = sent_q;
`else
  assign sent_count = '0;
`endif

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Testbench for leaf_stream_packetizer: directed scenarios, a queue-based
// transaction model checked every cycle, and hand-computed literal checks.
module tb_leaf_stream_packetizer;

`ifdef PACKETIZER_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] din = '0;
  logic        vld = 1'b0;
  logic        ack;
  logic        cfg_vld = 1'b0;
  logic [4:0]  cfg_leaf = '0;
  logic [3:0]  cfg_port = '0;
  logic        credit_upd = 1'b0;
  logic [48:0] pkt_out;
  logic        pkt_vld;
  logic        pkt_ack = 1'b0;
  logic [31:0] sent_count;

  always #5 clk = ~clk;

  leaf_stream_packetizer dut (
    .clk(clk), .reset(reset), .din(din), .vld(vld), .ack(ack),
    .cfg_vld(cfg_vld), .cfg_leaf(cfg_leaf), .cfg_port(cfg_port),
    .credit_upd(credit_upd), .pkt_out(pkt_out), .pkt_vld(pkt_vld),
    .pkt_ack(pkt_ack), .sent_count(sent_count)
  );

  int checks = 0;
  int failures = 0;

  // Transaction model state
  logic [31:0] m_q[$];
  bit          m_slot_vld;
  logic [48:0] m_slot_pkt;
  int          m_credit;
  int          m_addr;
  logic [4:0]  m_leaf;
  logic [3:0]  m_port;
  bit          m_cfgd;
  bit          m_ack;
  logic [31:0] m_sent;
  bit          model_started = 1'b0;

  // Handshake observation
  int          hs_count = 0;
  logic [48:0] last_pkt = '0;
  bit          watch_new = 1'b0;
  bit          seen_new = 1'b0;
  logic [48:0] new_pkt = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: each packet is a FIFO word behind the destination header; one
  // packet slot toward the arbiter; one credit per packet; updates add 64.
  always @(posedge clk) begin
    bit          consumed;
    bit          load;
    int          base_addr;
    int          nc;
    logic [4:0]  hl;
    logic [3:0]  hp;
    logic [31:0] word;
    model_started = 1'b1;
    if (reset) begin
      m_q.delete();
      m_slot_vld = 1'b0;
      m_slot_pkt = '0;
      m_credit   = 128;
      m_addr     = 0;
      m_leaf     = '0;
      m_port     = '0;
      m_cfgd     = 1'b0;
      m_ack      = 1'b0;
      m_sent     = '0;
    end else begin
      consumed  = m_slot_vld && pkt_ack;
      load      = m_cfgd && (m_q.size() > 0) && (m_credit > 0) && (!m_slot_vld || pkt_ack);
      hl        = cfg_vld ? cfg_leaf : m_leaf;
      hp        = cfg_vld ? cfg_port : m_port;
      base_addr = cfg_vld ? 0 : m_addr;
      if (load) begin
        word       = m_q.pop_front();
        m_slot_pkt = {1'b1, hl, hp, 7'(base_addr), word};
        m_addr     = (base_addr + 1) % 128;
      end else begin
        m_addr     = base_addr;
      end
      m_leaf = hl;
      m_port = hp;
      if (cfg_vld) m_cfgd = 1'b1;
      if (vld && m_ack) m_q.push_back(din);
      nc = m_credit - (load ? 1 : 0) + (credit_upd ? 64 : 0);
      m_credit = (nc > 128) ? 128 : nc;
      if (consumed) m_sent = m_sent + 32'd1;
      m_slot_vld = load ? 1'b1 : (consumed ? 1'b0 : m_slot_vld);
      m_ack = (m_q.size() != 16);
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (model_started) begin
      checkOutput("ack", ack, m_ack);
      checkOutput("pkt_vld", pkt_vld, m_slot_vld);
      checkOutput("pkt_out", pkt_out, m_slot_pkt);
      checkOutput("credit", dut.credit_q, m_credit);
      checkOutput("sent_count", sent_count, STATS_ON ? m_sent : 32'd0);
      if (pkt_vld && pkt_ack) begin
        hs_count++;
        last_pkt = pkt_out;
        if (watch_new && !seen_new && pkt_out[47:43] == 5'd9) begin
          seen_new = 1'b1;
          new_pkt  = pkt_out;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus(input bit v, input logic [31:0] d, input bit c,
                               input logic [4:0] l, input logic [3:0] p,
                               input bit u, output bit accepted);
    vld = v; din = d; cfg_vld = c; cfg_leaf = l; cfg_port = p; credit_upd = u;
    accepted = v && (ack === 1'b1);
    @(posedge clk); #1;
    vld = 1'b0; cfg_vld = 1'b0; credit_upd = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, acc);
  endtask

  task automatic configure(input logic [4:0] l, input logic [3:0] p);
    bit acc;
    applyStimulus(1'b0, '0, 1'b1, l, p, 1'b0, acc);
  endtask

  task automatic doReset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
  endtask

  task automatic pushWords(input int n, input logic [31:0] base);
    bit acc;
    int pushed = 0;
    int cycles = 0;
    while (pushed < n && cycles < 400) begin
      applyStimulus(1'b1, base + pushed, 1'b0, '0, '0, 1'b0, acc);
      if (acc) pushed++;
      cycles++;
    end
    checkOutput("push_count", pushed, n);
  endtask

  initial begin
    bit acc;
    int base_hs;
    int accepted;
    logic [63:0] c_before;

    // Reset values
    @(posedge clk); #1;
    checkOutput("reset_ack", ack, 0);
    checkOutput("reset_pkt_vld", pkt_vld, 0);
    checkOutput("reset_pkt_out", pkt_out, 0);
    checkOutput("reset_sent", sent_count, 0);
    idle(1);
    reset = 1'b0;
    idle(1);
    checkOutput("ack_after_reset", ack, 1);

    // Basic: two-cycle latency and header contents
    $display("[TB] basic");
    pkt_ack = 1'b1;
    configure(5'd3, 4'd2);
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, acc);
    checkOutput("basic_not_early", pkt_vld, 0);
    idle(1);
    checkOutput("basic_vld", pkt_vld, 1);
    checkOutput("basic_pkt", pkt_out, {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF});
    applyStimulus(1'b1, 32'h11111111, 1'b0, '0, '0, 1'b0, acc);
    idle(1);
    checkOutput("basic_pkt2", pkt_out, {1'b1, 5'd3, 4'd2, 7'd1, 32'h11111111});
    idle(3);

    // Credit exhaustion
    $display("[TB] credit exhaustion");
    doReset();
    configure(5'd4, 4'd1);
    base_hs = hs_count;
    pushWords(130, 32'h1000);
    idle(10);
    checkOutput("exh_sent", hs_count - base_hs, 128);
    checkOutput("exh_credit", dut.credit_q, 0);
    checkOutput("exh_fifo", dut.count_q, 2);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, acc);
    idle(6);
    checkOutput("exh_sent_after_upd", hs_count - base_hs, 130);
    checkOutput("exh_credit_final", dut.credit_q, 62);
    checkOutput("exh_last_payload", last_pkt[31:0], 32'h1000 + 129);

    // Backpressure
    $display("[TB] backpressure");
    doReset();
    configure(5'd2, 4'd6);
    pkt_ack = 1'b0;
    base_hs = hs_count;
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 32'h100 + accepted, 1'b0, '0, '0, 1'b0, acc);
      if (acc) accepted++;
    end
    checkOutput("bp_accepted", accepted, 17);
    checkOutput("bp_ack_low", ack, 0);
    checkOutput("bp_held_vld", pkt_vld, 1);
    checkOutput("bp_held_payload", pkt_out[31:0], 32'h100);
    pkt_ack = 1'b1;
    idle(25);
    checkOutput("bp_drained", hs_count - base_hs, 17);
    checkOutput("bp_last_payload", last_pkt[31:0], 32'h110);

    // Address wrap with a credit top-up that coincides with a packet load
    $display("[TB] wrap and reconfig");
    doReset();
    configure(5'd7, 4'd5);
    base_hs = hs_count;
    for (int i = 0; i < 129; i++) begin
      if (i == 70) begin
        c_before = dut.credit_q;
        checkOutput("sim_credit_before", c_before, 59);
        applyStimulus(1'b1, 32'h2000 + i, 1'b0, '0, '0, 1'b1, acc);
        checkOutput("sim_credit_after", dut.credit_q, 122);
      end else begin
        applyStimulus(1'b1, 32'h2000 + i, 1'b0, '0, '0, 1'b0, acc);
      end
      checkOutput("wrap_push_accepted", acc, 1);
    end
    idle(5);
    checkOutput("wrap_sent", hs_count - base_hs, 129);
    checkOutput("wrap_addr", last_pkt[38:32], 0);
    checkOutput("wrap_payload", last_pkt[31:0], 32'h2000 + 128);

    // Reconfiguration mid-stream
    watch_new = 1'b1;
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 32'h3000 + i, (i == 4), 5'd9, 4'd1, 1'b0, acc);
    idle(5);
    checkOutput("recfg_seen", seen_new, 1);
    checkOutput("recfg_addr", new_pkt[38:32], 0);
    checkOutput("recfg_port", new_pkt[42:39], 1);
    watch_new = 1'b0;

    // Reset while a packet is held in SEND
    $display("[TB] reset during send");
    doReset();
    configure(5'd1, 4'd1);
    pkt_ack = 1'b0;
    applyStimulus(1'b1, 32'hCAFE0001, 1'b0, '0, '0, 1'b0, acc);
    idle(2);
    checkOutput("rst_send_vld", pkt_vld, 1);
    reset = 1'b1;
    idle(1);
    checkOutput("rst_pkt_vld", pkt_vld, 0);
    checkOutput("rst_credit", dut.credit_q, 128);
    reset = 1'b0;
    idle(1);
    pushWords(1, 32'h55);
    idle(6);
    checkOutput("rst_uncfg_quiet", pkt_vld, 0);
    pkt_ack = 1'b1;
    configure(5'd12, 4'd3);
    idle(4);
    checkOutput("rst_after_cfg", last_pkt, {1'b1, 5'd12, 4'd3, 7'd0, 32'h55});

    // Statistics counter
    $display("[TB] stats");
    doReset();
    configure(5'd6, 4'd7);
    pushWords(10, 32'h4000);
    idle(5);
    checkOutput("stats_count", sent_count, STATS_ON ? 32'd10 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
